// File: rtl/seq_slot_table_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_slot_table_if : AXI-write, read-back and sequencer signals of the slot table
// Rev 1.0
// ---------------------------------------------------------------------------
interface seq_slot_table_if #(
  parameter int BANK1_INDEX_WIDTH    = 3,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK1_LD_MSK_WIDTH   = 8,
  parameter int BANK1_ST_MSK_WIDTH   = 8,
  parameter int DATA_WIDTH           = 32
);
  logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_inp_index;
  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_inp_src_addr;
  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_inp_src_size;
  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_inp_des_addr;
  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_inp_des_size;
  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_inp_status;
  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_inp_profile;
  logic [BANK1_LD_MSK_WIDTH-1:0]   ext_bank1_inp_ld_mask;
  logic [BANK1_ST_MSK_WIDTH-1:0]   ext_bank1_inp_st_mask;
  logic [BANK1_ST_MSK_WIDTH-1:0]   ext_bank1_inp_st_intr_mask_abs;
  logic ext_bank1_set_src_addr, ext_bank1_set_src_size, ext_bank1_set_des_addr;
  logic ext_bank1_set_des_size, ext_bank1_set_status, ext_bank1_set_profile;
  logic ext_bank1_set_ld_mask, ext_bank1_set_st_mask, ext_bank1_set_st_intr_mask_abs;

  logic [BANK1_INDEX_WIDTH-1:0]    rd_index;
  logic [3:0]                      rd_field;
  logic                            rd_en;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic                            rd_valid;

  logic [BANK1_INDEX_WIDTH-1:0]    seq_index;
  logic                            seq_load;
  logic                            seq_valid;
  logic [BANK1_SRC_ADDR_WIDTH-1:0] seq_src_addr;
  logic [BANK1_SRC_SIZE_WIDTH-1:0] seq_src_size;
  logic [BANK1_DST_ADDR_WIDTH-1:0] seq_des_addr;
  logic [BANK1_DST_SIZE_WIDTH-1:0] seq_des_size;
  logic [BANK1_LD_MSK_WIDTH-1:0]   seq_ld_mask;
  logic [BANK1_ST_MSK_WIDTH-1:0]   seq_st_mask;
  logic [BANK1_ST_MSK_WIDTH-1:0]   seq_st_intr_mask_abs;
  logic                            seq_set_status;
  logic [BANK1_STATUS_WIDTH-1:0]   seq_inp_status;
  logic                            seq_prof_en;
  logic                            seq_prof_clr;

  modport slave (
    input  ext_bank1_inp_index, ext_bank1_inp_src_addr, ext_bank1_inp_src_size,
           ext_bank1_inp_des_addr, ext_bank1_inp_des_size, ext_bank1_inp_status,
           ext_bank1_inp_profile, ext_bank1_inp_ld_mask, ext_bank1_inp_st_mask,
           ext_bank1_inp_st_intr_mask_abs,
           ext_bank1_set_src_addr, ext_bank1_set_src_size, ext_bank1_set_des_addr,
           ext_bank1_set_des_size, ext_bank1_set_status, ext_bank1_set_profile,
           ext_bank1_set_ld_mask, ext_bank1_set_st_mask, ext_bank1_set_st_intr_mask_abs,
           rd_index, rd_field, rd_en, seq_index, seq_load, seq_set_status,
           seq_inp_status, seq_prof_en, seq_prof_clr,
    output rd_data, rd_valid, seq_valid, seq_src_addr, seq_src_size, seq_des_addr,
           seq_des_size, seq_ld_mask, seq_st_mask, seq_st_intr_mask_abs
  );

  modport master (
    output ext_bank1_inp_index, ext_bank1_inp_src_addr, ext_bank1_inp_src_size,
           ext_bank1_inp_des_addr, ext_bank1_inp_des_size, ext_bank1_inp_status,
           ext_bank1_inp_profile, ext_bank1_inp_ld_mask, ext_bank1_inp_st_mask,
           ext_bank1_inp_st_intr_mask_abs,
           ext_bank1_set_src_addr, ext_bank1_set_src_size, ext_bank1_set_des_addr,
           ext_bank1_set_des_size, ext_bank1_set_status, ext_bank1_set_profile,
           ext_bank1_set_ld_mask, ext_bank1_set_st_mask, ext_bank1_set_st_intr_mask_abs,
           rd_index, rd_field, rd_en, seq_index, seq_load, seq_set_status,
           seq_inp_status, seq_prof_en, seq_prof_clr,
    input  rd_data, rd_valid, seq_valid, seq_src_addr, seq_src_size, seq_des_addr,
           seq_des_size, seq_ld_mask, seq_st_mask, seq_st_intr_mask_abs
  );
endinterface
`default_nettype wire

// File: rtl/seq_slot_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_slot_table : bank1 descriptor rows with read-back, snapshot and profiling
// Rev 1.0
// ---------------------------------------------------------------------------
module seq_slot_table #(
  parameter int BANK1_INDEX_WIDTH    = 3,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK1_LD_MSK_WIDTH   = 8,
  parameter int BANK1_ST_MSK_WIDTH   = 8,
  parameter int DATA_WIDTH           = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  seq_slot_table_if.slave   bus
);
  localparam int ROWS = 1 << BANK1_INDEX_WIDTH;

  logic [BANK1_SRC_ADDR_WIDTH-1:0] src_addr_q [ROWS];
  logic [BANK1_SRC_SIZE_WIDTH-1:0] src_size_q [ROWS];
  logic [BANK1_DST_ADDR_WIDTH-1:0] des_addr_q [ROWS];
  logic [BANK1_DST_SIZE_WIDTH-1:0] des_size_q [ROWS];
  logic [BANK1_STATUS_WIDTH-1:0]   status_q   [ROWS];
  logic [BANK1_PROFILE_WIDTH-1:0]  profile_q  [ROWS];
  logic [BANK1_LD_MSK_WIDTH-1:0]   ld_mask_q  [ROWS];
  logic [BANK1_ST_MSK_WIDTH-1:0]   st_mask_q  [ROWS];
  logic [BANK1_ST_MSK_WIDTH-1:0]   st_intr_q  [ROWS];

  logic [ROWS-1:0]       ext_sel, seq_sel;
  logic                  same_row;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_valid_q, seq_valid_q;
  logic [BANK1_SRC_ADDR_WIDTH-1:0] snap_src_addr_d, snap_src_addr_q;
  logic [BANK1_SRC_SIZE_WIDTH-1:0] snap_src_size_d, snap_src_size_q;
  logic [BANK1_DST_ADDR_WIDTH-1:0] snap_des_addr_d, snap_des_addr_q;
  logic [BANK1_DST_SIZE_WIDTH-1:0] snap_des_size_d, snap_des_size_q;
  logic [BANK1_LD_MSK_WIDTH-1:0]   snap_ld_mask_d, snap_ld_mask_q;
  logic [BANK1_ST_MSK_WIDTH-1:0]   snap_st_mask_d, snap_st_mask_q;
  logic [BANK1_ST_MSK_WIDTH-1:0]   snap_st_intr_d, snap_st_intr_q;

  always_comb begin
    ext_sel = '0;
    seq_sel = '0;
    ext_sel[bus.ext_bank1_inp_index] = 1'b1;
    seq_sel[bus.seq_index]           = 1'b1;
    same_row = (bus.ext_bank1_inp_index == bus.seq_index);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        src_addr_q[r] <= '0; src_size_q[r] <= '0; des_addr_q[r] <= '0;
        des_size_q[r] <= '0; status_q[r]   <= '0; profile_q[r]  <= '0;
        ld_mask_q[r]  <= '0; st_mask_q[r]  <= '0; st_intr_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (bus.ext_bank1_set_src_addr && ext_sel[r]) src_addr_q[r] <= bus.ext_bank1_inp_src_addr;
        if (bus.ext_bank1_set_src_size && ext_sel[r]) src_size_q[r] <= bus.ext_bank1_inp_src_size;
        if (bus.ext_bank1_set_des_addr && ext_sel[r]) des_addr_q[r] <= bus.ext_bank1_inp_des_addr;
        if (bus.ext_bank1_set_des_size && ext_sel[r]) des_size_q[r] <= bus.ext_bank1_inp_des_size;
        if (bus.ext_bank1_set_ld_mask  && ext_sel[r]) ld_mask_q[r]  <= bus.ext_bank1_inp_ld_mask;
        if (bus.ext_bank1_set_st_mask  && ext_sel[r]) st_mask_q[r]  <= bus.ext_bank1_inp_st_mask;
        if (bus.ext_bank1_set_st_intr_mask_abs && ext_sel[r])
          st_intr_q[r] <= bus.ext_bank1_inp_st_intr_mask_abs;

        // AXI writes win over sequencer updates only when they hit the same row
        if (bus.ext_bank1_set_status && ext_sel[r])
          status_q[r] <= bus.ext_bank1_inp_status;
        else if (bus.seq_set_status && seq_sel[r])
          status_q[r] <= bus.seq_inp_status;

        if (bus.ext_bank1_set_profile && ext_sel[r])
          profile_q[r] <= bus.ext_bank1_inp_profile;
        else if (bus.seq_prof_clr && seq_sel[r])
          profile_q[r] <= '0;
        else if (bus.seq_prof_en && seq_sel[r] && !(&profile_q[r]))
          profile_q[r] <= profile_q[r] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    case (bus.rd_field)
      4'd0: rd_data_d[BANK1_SRC_ADDR_WIDTH-1:0] = src_addr_q[bus.rd_index];
      4'd1: rd_data_d[BANK1_SRC_SIZE_WIDTH-1:0] = src_size_q[bus.rd_index];
      4'd2: rd_data_d[BANK1_DST_ADDR_WIDTH-1:0] = des_addr_q[bus.rd_index];
      4'd3: rd_data_d[BANK1_DST_SIZE_WIDTH-1:0] = des_size_q[bus.rd_index];
      4'd4: rd_data_d[BANK1_STATUS_WIDTH-1:0]   = status_q[bus.rd_index];
      4'd5: rd_data_d[BANK1_PROFILE_WIDTH-1:0]  = profile_q[bus.rd_index];
      4'd6: rd_data_d[BANK1_LD_MSK_WIDTH-1:0]   = ld_mask_q[bus.rd_index];
      4'd7: rd_data_d[BANK1_ST_MSK_WIDTH-1:0]   = st_mask_q[bus.rd_index];
      4'd8: rd_data_d[BANK1_ST_MSK_WIDTH-1:0]   = st_intr_q[bus.rd_index];
      default: rd_data_d = '0;
    endcase
  end

  // Snapshot bypass: a same-cycle AXI write to the snapshot row is taken directly
  always_comb begin
    snap_src_addr_d = (bus.ext_bank1_set_src_addr && same_row) ? bus.ext_bank1_inp_src_addr : src_addr_q[bus.seq_index];
    snap_src_size_d = (bus.ext_bank1_set_src_size && same_row) ? bus.ext_bank1_inp_src_size : src_size_q[bus.seq_index];
    snap_des_addr_d = (bus.ext_bank1_set_des_addr && same_row) ? bus.ext_bank1_inp_des_addr : des_addr_q[bus.seq_index];
    snap_des_size_d = (bus.ext_bank1_set_des_size && same_row) ? bus.ext_bank1_inp_des_size : des_size_q[bus.seq_index];
    snap_ld_mask_d  = (bus.ext_bank1_set_ld_mask  && same_row) ? bus.ext_bank1_inp_ld_mask  : ld_mask_q[bus.seq_index];
    snap_st_mask_d  = (bus.ext_bank1_set_st_mask  && same_row) ? bus.ext_bank1_inp_st_mask  : st_mask_q[bus.seq_index];
    snap_st_intr_d  = (bus.ext_bank1_set_st_intr_mask_abs && same_row) ?
                      bus.ext_bank1_inp_st_intr_mask_abs : st_intr_q[bus.seq_index];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      seq_valid_q     <= 1'b0;
      snap_src_addr_q <= '0; snap_src_size_q <= '0; snap_des_addr_q <= '0;
      snap_des_size_q <= '0; snap_ld_mask_q  <= '0; snap_st_mask_q  <= '0;
      snap_st_intr_q  <= '0;
    end else begin
      rd_valid_q  <= bus.rd_en;
      seq_valid_q <= bus.seq_load;
      if (bus.rd_en) rd_data_q <= rd_data_d;
      if (bus.seq_load) begin
        snap_src_addr_q <= snap_src_addr_d; snap_src_size_q <= snap_src_size_d;
        snap_des_addr_q <= snap_des_addr_d; snap_des_size_q <= snap_des_size_d;
        snap_ld_mask_q  <= snap_ld_mask_d;  snap_st_mask_q  <= snap_st_mask_d;
        snap_st_intr_q  <= snap_st_intr_d;
      end
    end
  end

  assign bus.rd_data              = rd_data_q;
  assign bus.rd_valid             = rd_valid_q;
  assign bus.seq_valid            = seq_valid_q;
  assign bus.seq_src_addr         = snap_src_addr_q;
  assign bus.seq_src_size         = snap_src_size_q;
  assign bus.seq_des_addr         = snap_des_addr_q;
  assign bus.seq_des_size         = snap_des_size_q;
  assign bus.seq_ld_mask          = snap_ld_mask_q;
  assign bus.seq_st_mask          = snap_st_mask_q;
  assign bus.seq_st_intr_mask_abs = snap_st_intr_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_slot_table.sv
`default_nettype none
// Testbench for seq_slot_table: directed test-plan steps followed by random traffic
// checked against a field-table reference model.
module tb_seq_slot_table;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_slot_table_if bus ();
  seq_slot_table dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Pending cycle stimulus
  int          wr_f, wr_idx, rd_idx, rd_fld, seq_idx;
  logic [31:0] wr_data;
  logic        rd_en, seq_load, seq_set_st, prof_en, prof_clr;
  logic [1:0]  seq_st;

  // Reference model: m[field][row], values kept truncated to field width
  logic [31:0] m [9][8];
  int          fw [9] = '{32, 26, 32, 26, 2, 32, 8, 8, 8};
  logic [31:0] exp_rd_data, exp_seq [9];
  logic        exp_rd_valid, exp_seq_valid;

  function automatic logic [31:0] trunc(int f, logic [31:0] d);
    if (fw[f] >= 32) return d;
    return d & ((32'd1 << fw[f]) - 32'd1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    bus.ext_bank1_inp_index            = 3'(wr_idx);
    bus.ext_bank1_inp_src_addr         = wr_data;
    bus.ext_bank1_inp_src_size         = wr_data[25:0];
    bus.ext_bank1_inp_des_addr         = wr_data;
    bus.ext_bank1_inp_des_size         = wr_data[25:0];
    bus.ext_bank1_inp_status           = wr_data[1:0];
    bus.ext_bank1_inp_profile          = wr_data;
    bus.ext_bank1_inp_ld_mask          = wr_data[7:0];
    bus.ext_bank1_inp_st_mask          = wr_data[7:0];
    bus.ext_bank1_inp_st_intr_mask_abs = wr_data[7:0];
    bus.ext_bank1_set_src_addr         = (wr_f == 0);
    bus.ext_bank1_set_src_size         = (wr_f == 1);
    bus.ext_bank1_set_des_addr         = (wr_f == 2);
    bus.ext_bank1_set_des_size         = (wr_f == 3);
    bus.ext_bank1_set_status           = (wr_f == 4);
    bus.ext_bank1_set_profile          = (wr_f == 5);
    bus.ext_bank1_set_ld_mask          = (wr_f == 6);
    bus.ext_bank1_set_st_mask          = (wr_f == 7);
    bus.ext_bank1_set_st_intr_mask_abs = (wr_f == 8);
    bus.rd_index       = 3'(rd_idx);
    bus.rd_field       = 4'(rd_fld);
    bus.rd_en          = rd_en;
    bus.seq_index      = 3'(seq_idx);
    bus.seq_load       = seq_load;
    bus.seq_set_status = seq_set_st;
    bus.seq_inp_status = seq_st;
    bus.seq_prof_en    = prof_en;
    bus.seq_prof_clr   = prof_clr;
  endtask

  task automatic idle();
    wr_f = -1; wr_idx = 0; wr_data = '0; rd_en = 1'b0; rd_idx = 0; rd_fld = 0;
    seq_load = 1'b0; seq_idx = 0; seq_set_st = 1'b0; seq_st = '0;
    prof_en = 1'b0; prof_clr = 1'b0;
  endtask

  task automatic model_clear();
    for (int f = 0; f < 9; f++) begin
      exp_seq[f] = '0;
      for (int r = 0; r < 8; r++) m[f][r] = '0;
    end
    exp_rd_data = '0; exp_rd_valid = 1'b0; exp_seq_valid = 1'b0;
  endtask

  // One clock: expectations from pre-edge contents, then apply the table rules
  task automatic step();
    logic [32:0] n;
    drive();
    exp_rd_valid  = rd_en;
    exp_seq_valid = seq_load;
    if (rd_en) exp_rd_data = (rd_fld < 9) ? m[rd_fld][rd_idx] : 32'd0;
    if (seq_load)
      for (int f = 0; f < 9; f++)
        exp_seq[f] = (wr_f == f && wr_idx == seq_idx) ? trunc(f, wr_data) : m[f][seq_idx];
    if (wr_f >= 0 && wr_f < 9) m[wr_f][wr_idx] = trunc(wr_f, wr_data);
    if (seq_set_st && !(wr_f == 4 && wr_idx == seq_idx)) m[4][seq_idx] = {30'd0, seq_st};
    if (!(wr_f == 5 && wr_idx == seq_idx)) begin
      if (prof_clr) m[5][seq_idx] = '0;
      else if (prof_en) begin
        n = {1'b0, m[5][seq_idx]} + 33'd1;
        m[5][seq_idx] = n[32] ? 32'hFFFF_FFFF : n[31:0];
      end
    end
    @(posedge clk);
    #1;
    idle();
    drive();
  endtask

  task automatic check_all(string ph);
    chk({ph, ".rd_valid"},  32'(bus.rd_valid),  32'(exp_rd_valid));
    chk({ph, ".rd_data"},   bus.rd_data,        exp_rd_data);
    chk({ph, ".seq_valid"}, 32'(bus.seq_valid), 32'(exp_seq_valid));
    chk({ph, ".seq_src_addr"}, 32'(bus.seq_src_addr), exp_seq[0]);
    chk({ph, ".seq_src_size"}, 32'(bus.seq_src_size), exp_seq[1]);
    chk({ph, ".seq_des_addr"}, 32'(bus.seq_des_addr), exp_seq[2]);
    chk({ph, ".seq_des_size"}, 32'(bus.seq_des_size), exp_seq[3]);
    chk({ph, ".seq_ld_mask"},  32'(bus.seq_ld_mask),  exp_seq[6]);
    chk({ph, ".seq_st_mask"},  32'(bus.seq_st_mask),  exp_seq[7]);
    chk({ph, ".seq_st_intr"},  32'(bus.seq_st_intr_mask_abs), exp_seq[8]);
  endtask

  task automatic do_read(int row, int fld);
    rd_en = 1'b1; rd_idx = row; rd_fld = fld;
    step();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    drive();
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // src_addr write / read-back, and an untouched neighbour row
    wr_f = 0; wr_idx = 5; wr_data = 32'hDEADBEEF; step(); check_all("wr_src");
    do_read(5, 0); check_all("rd_src5");
    chk("tp_src_addr", bus.rd_data, 32'hDEADBEEF);
    do_read(4, 0); check_all("rd_src4");
    chk("tp_src_addr_empty", bus.rd_data, 32'h0);

    // 26-bit truncation and an unused field code
    wr_f = 1; wr_idx = 5; wr_data = 32'hFFFFFFFF; step();
    do_read(5, 1); check_all("rd_size");
    chk("tp_trunc", bus.rd_data, 32'h03FFFFFF);
    do_read(5, 12); check_all("rd_f12");
    chk("tp_f12_valid", 32'(bus.rd_valid), 32'd1);
    chk("tp_f12_data", bus.rd_data, 32'd0);

    // status collisions
    wr_f = 4; wr_idx = 3; wr_data = 32'd2; seq_set_st = 1'b1; seq_idx = 3; seq_st = 2'd1; step();
    do_read(3, 4); chk("tp_st_same", bus.rd_data, 32'd2);
    wr_f = 4; wr_idx = 3; wr_data = 32'd2; seq_set_st = 1'b1; seq_idx = 4; seq_st = 2'd1; step();
    do_read(3, 4); check_all("rd_st3"); chk("tp_st3", bus.rd_data, 32'd2);
    do_read(4, 4); check_all("rd_st4"); chk("tp_st4", bus.rd_data, 32'd1);

    // profile saturation, clear priority, AXI load priority
    wr_f = 5; wr_idx = 2; wr_data = 32'hFFFFFFFD; step();
    for (int i = 0; i < 5; i++) begin seq_idx = 2; prof_en = 1'b1; step(); end
    do_read(2, 5); check_all("rd_prof_sat"); chk("tp_prof_sat", bus.rd_data, 32'hFFFFFFFF);
    seq_idx = 2; prof_en = 1'b1; prof_clr = 1'b1; step();
    do_read(2, 5); chk("tp_prof_clr", bus.rd_data, 32'd0);
    wr_f = 5; wr_idx = 2; wr_data = 32'd7; seq_idx = 2; prof_clr = 1'b1; step();
    do_read(2, 5); check_all("rd_prof_ld"); chk("tp_prof_ld", bus.rd_data, 32'd7);

    // snapshot with same-cycle write bypass
    wr_f = 2; wr_idx = 1; wr_data = 32'h1000; seq_load = 1'b1; seq_idx = 1; step();
    check_all("snap_byp");
    chk("tp_snap_valid", 32'(bus.seq_valid), 32'd1);
    chk("tp_snap_des", 32'(bus.seq_des_addr), 32'h1000);
    step(); check_all("snap_hold");

    // asynchronous reset while a read result is pending
    seq_load = 1'b1; seq_idx = 5; do_read(5, 0); check_all("pre_rst");
    #1 reset = 1'b0;
    #1;
    model_clear();
    check_all("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int f = 0; f < 9; f++) begin
        do_read(r, f); chk("post_rst_field", bus.rd_data, 32'd0);
      end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      wr_f       = int'($urandom_range(0, 11));
      wr_idx     = int'($urandom_range(0, 7));
      wr_data    = $urandom;
      if ($urandom_range(0, 3) == 0) wr_data = 32'hFFFF_FFFE + 32'($urandom_range(0, 1));
      rd_en      = 1'($urandom_range(0, 1));
      rd_idx     = int'($urandom_range(0, 7));
      rd_fld     = int'($urandom_range(0, 15));
      seq_load   = 1'($urandom_range(0, 1));
      seq_idx    = ($urandom_range(0, 3) == 0) ? wr_idx : int'($urandom_range(0, 7));
      seq_set_st = ($urandom_range(0, 3) == 0);
      seq_st     = 2'($urandom_range(0, 3));
      prof_en    = 1'($urandom_range(0, 1));
      prof_clr   = ($urandom_range(0, 7) == 0);
      step();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_slot_table.md
# seq_slot_table

Bank1 slot table storage for the DFX sequencer. It holds one descriptor row per slot: source/destination address and size, status, profile counter, load mask, store mask and store-interrupt mask. Rows are written by the AXI-Lite write decoder through per-field set strobes and a shared slot index. Rows are read back field-by-field for the AXI-Lite read path and as a whole-row snapshot for the sequencer core. The sequencer core can also update a slot's status and run that slot's cycle profile counter.

## Interface
Parameters:
- BANK1_INDEX_WIDTH, 3: slot index width; 2^BANK1_INDEX_WIDTH rows.
- BANK1_SRC_ADDR_WIDTH, 32: source address field width.
- BANK1_SRC_SIZE_WIDTH, 26: source size field width.
- BANK1_DST_ADDR_WIDTH, 32: destination address field width.
- BANK1_DST_SIZE_WIDTH, 26: destination size field width.
- BANK1_STATUS_WIDTH, 2: status field width.
- BANK1_PROFILE_WIDTH, 32: profile counter width.
- BANK1_LD_MSK_WIDTH, 8: load mask width.
- BANK1_ST_MSK_WIDTH, 8: store mask and store-interrupt mask width.
- DATA_WIDTH, 32: read-back data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- ext_bank1_inp_index  in  BANK1_INDEX_WIDTH  slot addressed by the AXI write.
- ext_bank1_inp_{src_addr,src_size,des_addr,des_size,status,profile,ld_mask,st_mask,st_intr_mask_abs}  in  field widths  write data for each field.
- ext_bank1_set_{src_addr,src_size,des_addr,des_size,status,profile,ld_mask,st_mask,st_intr_mask_abs}  in  1 each  single-cycle write strobes; at most one high per cycle.
- rd_index  in  BANK1_INDEX_WIDTH  slot to read back.
- rd_field  in  4  field code: 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status, 5 profile, 6 ld_mask, 7 st_mask, 8 st_intr_mask_abs.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read result, zero-extended.
- rd_valid  out  1  rd_data is valid.
- seq_index  in  BANK1_INDEX_WIDTH  slot used by the sequencer.
- seq_load  in  1  request a row snapshot.
- seq_valid  out  1  one-cycle pulse: snapshot outputs updated.
- seq_src_addr, seq_src_size, seq_des_addr, seq_des_size, seq_ld_mask, seq_st_mask, seq_st_intr_mask_abs  out  field widths  registered snapshot of the row.
- seq_set_status  in  1  write seq_inp_status into slot seq_index.
- seq_inp_status  in  BANK1_STATUS_WIDTH  new status value.
- seq_prof_en  in  1  increment the profile counter of slot seq_index this cycle.
- seq_prof_clr  in  1  clear the profile counter of slot seq_index.

## Operation
- Reset (reset low, asynchronous): every row field = 0; rd_data = 0; rd_valid = 0; every seq_* output = 0; seq_valid = 0.
- AXI write: a set strobe high at the clock edge writes the matching field of row ext_bank1_inp_index. Upper input bits beyond the field width are not present.
- Read-back: rd_en at edge N gives rd_data/rd_valid at N+1. rd_valid is a one-cycle pulse.
  - rd_field codes 9–15 return 0 with rd_valid = 1.
  - A read returns the pre-edge contents; no write bypass.
- Snapshot: seq_load at edge N latches all seq_* outputs from row seq_index; seq_valid pulses for one cycle. Outputs hold until the next seq_load.
  - Write-through bypass: if an AXI strobe targets the same row and field in the same cycle, the snapshot takes the new write data.
- Status, in priority order:
  - AXI set_status on the same slot wins over seq_set_status.
  - A collision on different slots writes both.
- Profile counter of slot seq_index, in priority order:
  1. AXI set_profile to that slot: load the written value.
  2. seq_prof_clr: load 0.
  3. seq_prof_en: add 1, saturating at all-ones (no wrap).
  - A profile write to another slot proceeds in parallel.
- Indices are full-range; no out-of-range case exists.

## Timing
- All state updates occur on the posedge of clk. No combinational path from any input to any output.
- Read latency is 1 cycle. Back-to-back rd_en every cycle is supported, giving one result per cycle.
- Snapshot latency is 1 cycle. seq_load on consecutive cycles gives consecutive snapshots.
- A profile increment is visible to read-back on the cycle after it occurs.
- Reset asserted mid-operation clears everything immediately; a pending rd_valid/seq_valid pulse is dropped.

## Test plan
- Write src_addr=0xDEADBEEF to slot 5, then rd_en slot 5 field 0 -> rd_valid at the next cycle, rd_data=0xDEADBEEF. Read slot 4 field 0 -> 0.
- Write src_size=0xFFFFFFFF -> read-back gives 0x03FFFFFF (26-bit truncation). rd_field=12 -> rd_data=0, rd_valid=1.
- Same-cycle AXI set_status=2 and seq_set_status=1 on slot 3 -> status=2. Same cycle on slots 3 and 4 -> slot 3=2, slot 4=1.
- Profile on slot 2:
  - AXI writes 0xFFFFFFFD, then seq_prof_en held 5 cycles -> counter 0xFFFFFFFF (saturated).
  - seq_prof_clr together with seq_prof_en -> 0.
  - AXI set_profile=7 together with seq_prof_clr -> 7.
- seq_load on slot 1 in the same cycle as an AXI des_addr=0x1000 write to slot 1 -> the next cycle shows seq_valid=1 and seq_des_addr=0x1000.
- Reset asserted while rd_valid is pending -> rd_valid=0 and rd_data=0 immediately; all fields read 0 after release.
